mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory + writeback stage of the 5-stage RV64 pipeline; producer side of the EX-stage forwarding path.
//  Registers EX results into EX/MEM and performs the load/store on the data-memory req/ready interface.
//  Registers the writeback value into MEM/WB and drives both forwarding sources (EX/MEM ALU value, MEM/WB
//  writeback value) with their Rd/RegWrite tags. Raises stall when memory is slow.
// PARAMETERS
//  XLEN        64  datapath width
//  ADDR_W      64  data-memory address width (low ADDR_W bits of ALU result)
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     asynchronous active-low reset
//  ex_valid        in   1     EX stage holds a valid instruction this cycle
//  ex_alu_result   in   XLEN  ALU result / effective address
//  ex_store_data   in   XLEN  forwarded RS2 value for stores
//  ex_rd           in   5     destination register
//  ex_ctrl         in   4     {RegWrite, MemtoReg, MemRead, MemWrite}
//  exmem_alu       out  XLEN  EX/MEM ALU value (forward source 1)
//  exmem_rd        out  5     EX/MEM Rd tag
//  exmem_regwrite  out  1     EX/MEM RegWrite, qualified by valid
//  memwb_data      out  XLEN  writeback value (forward source 2, regfile write data)
//  memwb_rd        out  5     MEM/WB Rd tag
//  memwb_regwrite  out  1     MEM/WB RegWrite, qualified by valid; 0 when rd==x0
//  stall           out  1     hold IF/ID/EX; EX/MEM must not be overwritten
//  dmem_req        out  1     memory request
//  dmem_we         out  1     1=store, 0=load
//  dmem_addr       out  ADDR_W
//  dmem_wdata      out  XLEN
//  dmem_ready      in   1     access completes this cycle (rdata valid for loads)
//  dmem_rdata      in   XLEN
//  mem_misalign    out  1     only with MEM_MISALIGN_TRAP_EN; else tied 0
// BEHAVIOUR
//  Reset: every register and output 0; FSM=IDLE; stall=0, dmem_req=0.
//  EX/MEM loads {ex_*} every cycle stall==0; with stall==1 it holds. ex_valid=0 loads a bubble (valid=0).
//  FSM on the EX/MEM entry: IDLE, ACCESS.
//   IDLE: entry valid & (MemRead|MemWrite) -> dmem_req=1 combinationally; if dmem_ready same cycle: done
//     (0 stall cycles), else stall=1 and next=ACCESS.
//   ACCESS: dmem_req=1, addr/we/wdata held constant from EX/MEM; stall=!dmem_ready; ready -> IDLE.
//  Non-memory valid entry: no req, passes to MEM/WB next cycle. dmem_req never asserted for a bubble.
//  MEM/WB: on completion cycle (non-mem, or mem with dmem_ready) latch valid, rd, regwrite, data =
//   MemtoReg ? dmem_rdata : alu; while stalled MEM/WB loads a bubble (valid=0, regwrite=0).
//  Latency: ALU op 2 edges EX->MEM/WB; load 2 + N edges for N wait cycles.
//  Stores: regwrite forced 0 in MEM/WB regardless of ex_ctrl. rd==x0 never produces regwrite=1.
//  Back-to-back mem ops: new request issues the cycle after prior ready; no idle cycle inserted.
//  Store data/addr unaffected by a concurrent MEM/WB write to the same register (forwarded upstream).
//  Async reset mid-ACCESS: drop req immediately, FSM=IDLE, pending access abandoned.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: mem op with addr[2:0]!=0 issues no req, 0 stall cycles, becomes
//   a bubble in MEM/WB (regwrite=0) and pulses mem_misalign=1 for one cycle, registered with MEM/WB.
//  Undefined: address passed unmodified; mem_misalign tied 0; memory owns alignment.
// STRUCTURE
//  Package riscv_pipe_pkg: ctrl bit indices (CTRL_REGWRITE..CTRL_MEMWRITE), mem_fsm_t {IDLE,ACCESS},
//   XLEN default, REG_X0 constant.
//  One sub-module: mem_wb_reg (MEM/WB register with bubble insert, x0 suppression). FSM and EX/MEM here.
// TESTING
//  ALU op rd=5 val=0x1234, ready n/a -> exmem_alu=0x1234 after 1 edge, memwb_data=0x1234 rd=5 rw=1 after 2.
//  Load addr 0x100, ready held 0 for 3 cycles then 1 with rdata=0xDEAD -> stall=1 exactly 3 cycles,
//   req/addr stable, memwb_data=0xDEAD next edge; MEM/WB bubble during stall.
//  Store addr 0x08 wdata 0xCAFE, ready=1 same cycle -> we=1, no stall, memwb_regwrite=0.
//  ALU op rd=0 -> memwb_regwrite=0; two back-to-back loads ready=1 -> two reqs consecutive cycles.
//  rst_n low during ACCESS -> dmem_req=0 and all outputs 0 without clock edge; resume clean after.
//  With MEM_MISALIGN_TRAP_EN, load addr 0x103 -> no req, mem_misalign=1 one cycle, memwb_regwrite=0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared constants and types for the RV64 pipeline MEM/WB slice
package riscv_pipe_pkg;

  localparam int XLEN_DEF = 64;
  localparam logic [4:0] REG_X0 = 5'd0;

  // ex_ctrl bit positions: {RegWrite, MemtoReg, MemRead, MemWrite}
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_fsm_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble insert and x0 write suppression
module mem_wb_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid_i,
  input  logic [4:0]      rd_i,
  input  logic            regwrite_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            misalign_i,
  output logic [XLEN-1:0] data_o,
  output logic [4:0]      rd_o,
  output logic            regwrite_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] data_q, data_d;
  logic [4:0]      rd_q, rd_d;
  logic            regwrite_q, regwrite_d;
  logic            misalign_q, misalign_d;

  // A bubble only clears regwrite; data/rd keep their last value.
  always_comb begin
    data_d     = data_q;
    rd_d       = rd_q;
    regwrite_d = load_valid_i & regwrite_i & (rd_i != REG_X0);
    misalign_d = misalign_i;
    if (load_valid_i) begin
      data_d = data_i;
      rd_d   = rd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      misalign_q <= misalign_d;
    end
  end

  assign data_o     = data_q;
  assign rd_o       = rd_q;
  assign regwrite_o = regwrite_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - EX/MEM register, data-memory access FSM and MEM/WB forwarding sources
// Optional build macro: MEM_MISALIGN_TRAP_EN
module mem_wb_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic [3:0]        ex_ctrl,
  output logic [XLEN-1:0]   exmem_alu,
  output logic [4:0]        exmem_rd,
  output logic              exmem_regwrite,
  output logic [XLEN-1:0]   memwb_data,
  output logic [4:0]        memwb_rd,
  output logic              memwb_regwrite,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_misalign
);

  logic            exm_valid_q, exm_valid_d;
  logic [XLEN-1:0] exm_alu_q, exm_alu_d;
  logic [XLEN-1:0] exm_wdata_q, exm_wdata_d;
  logic [4:0]      exm_rd_q, exm_rd_d;
  logic [3:0]      exm_ctrl_q, exm_ctrl_d;
  mem_fsm_t        state_q, state_d;

  logic mem_op, misalign_w, mem_go, complete;

  // EX/MEM freezes while the memory access is outstanding
  always_comb begin
    exm_valid_d = ex_valid;
    exm_alu_d   = ex_alu_result;
    exm_wdata_d = ex_store_data;
    exm_rd_d    = ex_rd;
    exm_ctrl_d  = ex_ctrl;
    if (stall) begin
      exm_valid_d = exm_valid_q;
      exm_alu_d   = exm_alu_q;
      exm_wdata_d = exm_wdata_q;
      exm_rd_d    = exm_rd_q;
      exm_ctrl_d  = exm_ctrl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_valid_q <= 1'b0;
      exm_alu_q   <= '0;
      exm_wdata_q <= '0;
      exm_rd_q    <= '0;
      exm_ctrl_q  <= '0;
      state_q     <= IDLE;
    end else begin
      exm_valid_q <= exm_valid_d;
      exm_alu_q   <= exm_alu_d;
      exm_wdata_q <= exm_wdata_d;
      exm_rd_q    <= exm_rd_d;
      exm_ctrl_q  <= exm_ctrl_d;
      state_q     <= state_d;
    end
  end

  assign mem_op = exm_valid_q & (exm_ctrl_q[CTRL_MEMREAD] | exm_ctrl_q[CTRL_MEMWRITE]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_w = mem_op & (exm_alu_q[2:0] != 3'b000);
`else
  assign misalign_w = 1'b0;
`endif

  assign mem_go = mem_op & ~misalign_w;

  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        dmem_req = mem_go;
        stall    = mem_go & ~dmem_ready;
        state_d  = (mem_go & ~dmem_ready) ? ACCESS : IDLE;
      end
      ACCESS: begin
        dmem_req = 1'b1;
        stall    = ~dmem_ready;
        state_d  = dmem_ready ? IDLE : ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  assign complete = exm_valid_q & ~stall & ~misalign_w;

  mem_wb_reg #(.XLEN(XLEN)) u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid_i (complete),
    .rd_i         (exm_rd_q),
    .regwrite_i   (exm_ctrl_q[CTRL_REGWRITE] & ~exm_ctrl_q[CTRL_MEMWRITE]),
    .data_i       (exm_ctrl_q[CTRL_MEMTOREG] ? dmem_rdata : exm_alu_q),
    .misalign_i   (misalign_w),
    .data_o       (memwb_data),
    .rd_o         (memwb_rd),
    .regwrite_o   (memwb_regwrite),
    .misalign_o   (mem_misalign)
  );

  assign exmem_alu      = exm_alu_q;
  assign exmem_rd       = exm_rd_q;
  assign exmem_regwrite = exm_valid_q & exm_ctrl_q[CTRL_REGWRITE];
  assign dmem_we        = exm_ctrl_q[CTRL_MEMWRITE];
  assign dmem_addr      = exm_alu_q[ADDR_W-1:0];
  assign dmem_wdata     = exm_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed vector bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_ctrl;
  logic [63:0] exmem_alu, memwb_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite, stall, dmem_req, dmem_we, dmem_ready, mem_misalign;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .exmem_alu(exmem_alu), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_data(memwb_data), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_misalign(mem_misalign)
  );

  typedef struct {
    logic [63:0] alu;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        exp_req;
    logic        exp_we;
    logic        exp_exrw;
    logic [63:0] exp_wb;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [63:0] alu, input logic [63:0] wd,
                          input logic [4:0] rd, input logic [3:0] ctrl);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_store_data = wd;
    ex_rd         = rd;
    ex_ctrl       = ctrl;
  endtask

  initial begin
    // {alu, wdata, rdata, rd, ctrl, req, we, exmem_rw, wb_data, wb_rw}
    vecs[0] = '{64'h1234, 64'h0,    64'h0,    5'd5, 4'b1000, 1'b0, 1'b0, 1'b1, 64'h1234, 1'b1};
    vecs[1] = '{64'h55,   64'h0,    64'h0,    5'd0, 4'b1000, 1'b0, 1'b0, 1'b1, 64'h55,   1'b0};
    vecs[2] = '{64'h08,   64'hCAFE, 64'h0,    5'd7, 4'b1001, 1'b1, 1'b1, 1'b1, 64'h08,   1'b0};
    vecs[3] = '{64'h200,  64'h0,    64'hBEEF, 5'd3, 4'b1110, 1'b1, 1'b0, 1'b1, 64'hBEEF, 1'b1};
    vecs[4] = '{64'h99,   64'h0,    64'h0,    5'd9, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h99,   1'b0};

    rst_n = 1'b0;
    drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
    dmem_ready = 1'b0;
    dmem_rdata = 64'h0;
    #12;
    chk("rst_exmem_alu", exmem_alu, 64'h0);
    chk("rst_exmem_rw", {63'h0, exmem_regwrite}, 64'h0);
    chk("rst_memwb_data", memwb_data, 64'h0);
    chk("rst_memwb_rw", {63'h0, memwb_regwrite}, 64'h0);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    chk("rst_req", {63'h0, dmem_req}, 64'h0);
    chk("rst_misalign", {63'h0, mem_misalign}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Single-instruction vectors, ready=1 so memory ops finish with no stall
    for (int i = 0; i < 5; i++) begin
      drive_ex(1'b1, vecs[i].alu, vecs[i].wdata, vecs[i].rd, vecs[i].ctrl);
      dmem_ready = 1'b1;
      dmem_rdata = vecs[i].rdata;
      tick();
      drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
      chk($sformatf("v%0d_exmem_alu", i), exmem_alu, vecs[i].alu);
      chk($sformatf("v%0d_exmem_rd", i), {59'h0, exmem_rd}, {59'h0, vecs[i].rd});
      chk($sformatf("v%0d_exmem_rw", i), {63'h0, exmem_regwrite}, {63'h0, vecs[i].exp_exrw});
      chk($sformatf("v%0d_req", i), {63'h0, dmem_req}, {63'h0, vecs[i].exp_req});
      chk($sformatf("v%0d_stall", i), {63'h0, stall}, 64'h0);
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_we", i), {63'h0, dmem_we}, {63'h0, vecs[i].exp_we});
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu);
        chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
      end
      tick();
      chk($sformatf("v%0d_wb_data", i), memwb_data, vecs[i].exp_wb);
      chk($sformatf("v%0d_wb_rd", i), {59'h0, memwb_rd}, {59'h0, vecs[i].rd});
      chk($sformatf("v%0d_wb_rw", i), {63'h0, memwb_regwrite}, {63'h0, vecs[i].exp_rw});
      dmem_ready = 1'b0;
      tick();
    end

    // Load with three wait cycles; EX keeps offering a new op that must not overwrite EX/MEM
    drive_ex(1'b1, 64'h100, 64'h0, 5'd4, 4'b1110);
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_ex(1'b1, 64'hBAD0, 64'h0, 5'd11, 4'b1000);
      chk($sformatf("ws%0d_stall", i), {63'h0, stall}, 64'h1);
      chk($sformatf("ws%0d_req", i), {63'h0, dmem_req}, 64'h1);
      chk($sformatf("ws%0d_addr", i), dmem_addr, 64'h100);
      chk($sformatf("ws%0d_exmem_alu", i), exmem_alu, 64'h100);
      chk($sformatf("ws%0d_wb_rw", i), {63'h0, memwb_regwrite}, 64'h0);
    end
    drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
    dmem_ready = 1'b1;
    dmem_rdata = 64'hDEAD;
    #1;
    chk("ws_done_stall", {63'h0, stall}, 64'h0);
    tick();
    dmem_ready = 1'b0;
    chk("ws_wb_data", memwb_data, 64'hDEAD);
    chk("ws_wb_rd", {59'h0, memwb_rd}, 64'd4);
    chk("ws_wb_rw", {63'h0, memwb_regwrite}, 64'h1);
    tick();

    // Back-to-back loads, both ready immediately
    drive_ex(1'b1, 64'h10, 64'h0, 5'd12, 4'b1110);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 64'hA1;
    drive_ex(1'b1, 64'h18, 64'h0, 5'd13, 4'b1110);
    #1;
    chk("bb0_req", {63'h0, dmem_req}, 64'h1);
    chk("bb0_addr", dmem_addr, 64'h10);
    tick();
    dmem_rdata = 64'hB2;
    drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
    #1;
    chk("bb1_req", {63'h0, dmem_req}, 64'h1);
    chk("bb1_addr", dmem_addr, 64'h18);
    chk("bb1_wb_data", memwb_data, 64'hA1);
    tick();
    chk("bb2_req", {63'h0, dmem_req}, 64'h0);
    chk("bb2_wb_data", memwb_data, 64'hB2);
    chk("bb2_wb_rd", {59'h0, memwb_rd}, 64'd13);
    dmem_ready = 1'b0;
    tick();

    // Asynchronous reset during ACCESS
    drive_ex(1'b1, 64'h40, 64'h0, 5'd8, 4'b1110);
    tick();
    drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
    chk("ar_req_before", {63'h0, dmem_req}, 64'h1);
    chk("ar_stall_before", {63'h0, stall}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", {63'h0, dmem_req}, 64'h0);
    chk("ar_stall", {63'h0, stall}, 64'h0);
    chk("ar_addr", dmem_addr, 64'h0);
    chk("ar_exmem_alu", exmem_alu, 64'h0);
    chk("ar_wb_data", memwb_data, 64'h0);
    chk("ar_wb_rw", {63'h0, memwb_regwrite}, 64'h0);
    tick();
    rst_n = 1'b1;
    drive_ex(1'b1, 64'h77, 64'h0, 5'd6, 4'b1000);
    tick();
    drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
    chk("ar_resume_req", {63'h0, dmem_req}, 64'h0);
    tick();
    chk("ar_resume_wb", memwb_data, 64'h77);
    chk("ar_resume_rw", {63'h0, memwb_regwrite}, 64'h1);
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    drive_ex(1'b1, 64'h103, 64'h0, 5'd2, 4'b1110);
    dmem_ready = 1'b0;
    tick();
    drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
    chk("ma_req", {63'h0, dmem_req}, 64'h0);
    chk("ma_stall", {63'h0, stall}, 64'h0);
    tick();
    chk("ma_flag", {63'h0, mem_misalign}, 64'h1);
    chk("ma_wb_rw", {63'h0, memwb_regwrite}, 64'h0);
    tick();
    chk("ma_flag_clear", {63'h0, mem_misalign}, 64'h0);
`else
    drive_ex(1'b1, 64'h103, 64'h0, 5'd2, 4'b1110);
    dmem_ready = 1'b1;
    dmem_rdata = 64'h5A;
    tick();
    drive_ex(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000);
    chk("ua_req", {63'h0, dmem_req}, 64'h1);
    chk("ua_addr", dmem_addr, 64'h103);
    tick();
    chk("ua_misalign", {63'h0, mem_misalign}, 64'h0);
    chk("ua_wb_data", memwb_data, 64'h5A);
    dmem_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
